// File: rtl/loss_pkg.sv
// Shared types and default sizing for the L1-loss sequencer.
package loss_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_ACC_W  = 48;

    // Largest value the default-width loss accumulator can hold.
    localparam logic [DEF_ACC_W-1:0] DEF_SAT_LIMIT = '1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/loss_block.sv
// Per-element L1 stage: registers |data - target| with one cycle of latency.
module loss_block (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] data_in,
    input  logic [31:0] target_in,
    output logic        valid_out,
    output logic [31:0] loss_out
);

    logic [31:0] abs_diff;

    // Subtract the smaller operand from the larger one; the true magnitude
    // always fits in 32 unsigned bits, so the wrapped difference is exact.
    always_comb begin
        abs_diff = '0;
        if ($signed(data_in) >= $signed(target_in)) begin
            abs_diff = data_in - target_in;
        end else begin
            abs_diff = target_in - data_in;
        end
    end

    // Output register: valid follows valid_in, loss only captured when valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out <= 1'b0;
            loss_out  <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                loss_out <= abs_diff;
            end
        end
    end

endmodule

// File: rtl/loss_sequencer.sv
// Sequences one L1-loss pass: issues buffer reads, feeds the returned pairs
// through loss_block and accumulates a saturating sum and a running maximum.
module loss_sequencer
    import loss_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] len_in,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       out_rdata,
    input  logic [31:0]       tgt_rdata,
    output logic [ACC_W-1:0]  loss_sum,
    output logic [31:0]       max_loss,
    output logic              done
);

    localparam logic [ACC_W-1:0] SAT_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] issue_cnt;
    logic              accept;
    logic              last_issue;
    logic              mem_valid;
    logic              lb_valid;
    logic [31:0]       lb_loss;
    logic [ACC_W:0]    sum_wide;

    assign accept     = (state == IDLE) && start;
    assign last_issue = (issue_cnt == (len_q - 1'b1));
    assign rd_addr    = issue_cnt;
    assign sum_wide   = {1'b0, loss_sum} + {{(ACC_W + 1 - 32){1'b0}}, lb_loss};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    // DRAIN leaves as soon as nothing is waiting in front of loss_block: the
    // last loss_out still valid this cycle is accumulated on the same edge
    // that enters DONE, so the results are already final while done is high.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len_in != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!mem_valid) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy  = (state != IDLE);
        rd_en = (state == ISSUE);
        done  = (state == DONE);
    end

    // Length latch and issue counter; the counter holds at len-1 after issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q     <= '0;
            issue_cnt <= '0;
        end else if (accept) begin
            len_q     <= len_in;
            issue_cnt <= '0;
        end else if ((state == ISSUE) && !last_issue) begin
            issue_cnt <= issue_cnt + 1'b1;
        end
    end

    // Read data returns one cycle after the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid <= 1'b0;
        end else begin
            mem_valid <= rd_en;
        end
    end

    loss_block u_loss_block (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (mem_valid),
        .data_in   (out_rdata),
        .target_in (tgt_rdata),
        .valid_out (lb_valid),
        .loss_out  (lb_loss)
    );

    // Saturating loss sum and running maximum, cleared when a pass is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loss_sum <= '0;
            max_loss <= '0;
        end else if (accept) begin
            loss_sum <= '0;
            max_loss <= '0;
        end else if (lb_valid) begin
            loss_sum <= sum_wide[ACC_W] ? SAT_MAX : sum_wide[ACC_W-1:0];
            if (lb_loss > max_loss) begin
                max_loss <= lb_loss;
            end
        end
    end

endmodule

// File: tb/tb_loss_sequencer.sv
// Randomized scoreboard bench for loss_sequencer with a behavioural L1 model.
module tb_loss_sequencer;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned ACC_W  = 33;
    localparam longint      SAT    = (64'sd1 <<< ACC_W) - 1;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic [31:0]      mx;
        longint           cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] len_in = '0;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       out_rdata = '0;
    logic [31:0]       tgt_rdata = '0;
    logic [ACC_W-1:0]  loss_sum;
    logic [31:0]       max_loss;
    logic              done;

    logic [31:0]       out_mem [256];
    logic [31:0]       tgt_mem [256];
    exp_t              exp_q [$];
    logic [ADDR_W-1:0] addr_q [$];
    int                n_cmp = 0;
    int                n_bad = 0;
    longint            cyc = 0;
    logic [ACC_W-1:0]  last_sum = '0;
    logic [31:0]       last_max = '0;

    loss_sequencer #(.ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len_in    (len_in),
        .busy      (busy),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .out_rdata (out_rdata),
        .tgt_rdata (tgt_rdata),
        .loss_sum  (loss_sum),
        .max_loss  (max_loss),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Buffer model: data for a strobe appears one cycle later; garbage otherwise.
    initial begin : mem_model
        logic              pend;
        logic [ADDR_W-1:0] pa;
        pend = 1'b0;
        pa   = '0;
        forever begin
            @(negedge clk);
            if (pend) begin
                out_rdata = out_mem[pa];
                tgt_rdata = tgt_mem[pa];
            end else begin
                out_rdata = $urandom;
                tgt_rdata = $urandom;
            end
            pend = rd_en;
            pa   = rd_addr;
        end
    end

    // Monitor: pops expectations whenever the DUT presents a read or a result.
    initial begin : monitor
        exp_t              e;
        logic [ADDR_W-1:0] a;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rd_en) begin
                    if (addr_q.size() == 0) begin
                        check("rd_en_unexpected", rd_en, 0);
                    end else begin
                        a = addr_q.pop_front();
                        check("rd_addr", rd_addr, a);
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("done_unexpected", done, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("loss_sum", loss_sum, e.sum);
                        check("max_loss", max_loss, e.mx);
                        check("done_cycle", cyc, e.cyc);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    // Reference model plus stimulus for one pass over out_mem/tgt_mem[0..n-1].
    task automatic run_pass(input int n, input bit mid, input bit at_done);
        longint      s;
        longint      d;
        logic [31:0] mx;
        s  = 0;
        mx = '0;
        for (int i = 0; i < n; i++) begin
            d = longint'($signed(out_mem[i])) - longint'($signed(tgt_mem[i]));
            if (d < 0) d = -d;
            s = s + d;
            if (s > SAT) s = SAT;
            if (d > longint'(mx)) mx = d[31:0];
            addr_q.push_back(i[ADDR_W-1:0]);
        end
        exp_q.push_back('{s[ACC_W-1:0], mx, cyc + ((n == 0) ? 1 : n + 3)});
        last_sum = s[ACC_W-1:0];
        last_max = mx;
        len_in = n[ADDR_W-1:0];
        start  = 1'b1;
        @(negedge clk);
        start  = (n == 0) && at_done;
        len_in = ADDR_W'($urandom);
        check("busy_cycle1", busy, 1);
        if (n > 0) begin
            for (int k = 2; k <= n + 3; k++) begin
                @(negedge clk);
                start = (mid && k == 2) || (at_done && k == n + 3);
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            check("hold_busy", busy, 0);
            check("hold_sum", loss_sum, last_sum);
            check("hold_max", max_loss, last_max);
            @(negedge clk);
        end
    endtask

    task automatic abort_pass(input int n);
        for (int i = 0; i < n; i++) addr_q.push_back(i[ADDR_W-1:0]);
        len_in = n[ADDR_W-1:0];
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_rd_en", rd_en, 0);
        check("abort_rd_addr", rd_addr, 0);
        check("abort_sum", loss_sum, 0);
        check("abort_max", max_loss, 0);
        check("abort_done", done, 0);
        addr_q.delete();
        @(negedge clk);
        reset = 1'b0;
        last_sum = '0;
        last_max = '0;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 4))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return $urandom;
            default: return 32'($signed($urandom_range(0, 2000)) - 1000);
        endcase
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            out_mem[i] = rand_word();
            tgt_mem[i] = rand_word();
        end
    endtask

    initial begin : stimulus
        int n;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_sum", loss_sum, 0);
        check("rst_max", max_loss, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic sum: losses {7,10,0,9}.
        out_mem[0] = 32'd10;  tgt_mem[0] = 32'd3;
        out_mem[1] = -32'sd5; tgt_mem[1] = 32'd5;
        out_mem[2] = 32'd7;   tgt_mem[2] = 32'd7;
        out_mem[3] = 32'd0;   tgt_mem[3] = -32'sd9;
        run_pass(4, 0, 0);
        idle(3);

        // Empty pass.
        run_pass(0, 0, 0);
        idle(2);

        // Saturation with maximal per-element losses.
        for (int i = 0; i < 3; i++) begin
            out_mem[i] = 32'h7FFF_FFFF;
            tgt_mem[i] = 32'h8000_0000;
        end
        run_pass(3, 0, 0);
        idle(2);

        // start pulses during ISSUE and in the done cycle are ignored.
        fill_random(6);
        run_pass(6, 1, 1);
        idle(2);
        run_pass(0, 0, 1);
        idle(1);

        // Reset mid-pass, then a clean short pass.
        fill_random(8);
        abort_pass(8);
        idle(2);
        fill_random(2);
        run_pass(2, 0, 0);
        idle(1);

        // Back-to-back passes.
        fill_random(5);
        run_pass(5, 0, 0);
        fill_random(3);
        run_pass(3, 0, 0);
        idle(2);

        // Randomized passes with random gaps and ignored start pulses.
        for (int p = 0; p < 40; p++) begin
            n = $urandom_range(0, 24);
            fill_random(n);
            run_pass(n, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            idle($urandom_range(0, 3));
        end

        // Longest vector.
        fill_random(255);
        run_pass(255, 0, 0);
        idle(4);

        check("exp_q_drained", exp_q.size(), 0);
        check("addr_q_drained", addr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
